lvds_pll_sequencer: RTL
=======================

Name: lvds_pll_sequencer

Overview:
- Power-up and lock controller for the 48 MHz -> 336 MHz LVDS serializer PLL (EHXPLLL, 7:1 bit clock).
- Drives PLL RST/STDBY/ENCLKOP and monitors LOCK.
- Releases the downstream LVDS serializer reset only after lock is stable.
- On timeout or lock loss it retries the PLL, up to a limit, and then latches a fault for the STM32.
- Runs on the PLL reference clock, beside the PLL instance in the top level.

Parameters:
- CNT_W, 17, width of the shared cycle counter; must hold the largest count below.
- RST_CYCLES, 16, cycles pllRst is held high per attempt.
- LOCK_STABLE_CYCLES, 4800, consecutive synced-lock cycles required (100 us @ 48 MHz).
- LOCK_TIMEOUT_CYCLES, 48000, maximum cycles to wait for stable lock per attempt (1 ms).
- ENABLE_GAP, 8, cycles between pllEnClkop rising and lvdsResetN rising.
- MAX_RETRIES, 3, failed attempts allowed before entering FAULT (>=1).

Ports:
- pllInClock  in  1  48 MHz reference clock, the block's only clock.
- resetN  in  1  asynchronous active-low reset.
- enableReq  in  1  panel LVDS enable; synchronous to pllInClock (synchronised upstream).
- pllLock  in  1  PLL LOCK, asynchronous; 2-flop synchronised internally.
- pllRst  out  1  to PLL RST.
- pllStdby  out  1  to PLL STDBY.
- pllEnClkop  out  1  to PLL ENCLKOP.
- lvdsResetN  out  1  active-low reset to the serializer.
- ready  out  1  equals lvdsResetN.
- fault  out  1  retries exhausted.
- retryCount  out  2  failed attempts in the current enable session (saturates at 3).

Behaviour:
- All outputs are registered and update on the same edge as the state register.
- Reset values: pllRst=1, pllStdby=1, pllEnClkop=0, lvdsResetN=0, ready=0, fault=0, retryCount=0, state=IDLE, counters=0, sync flops=0.
- lockS is pllLock after 2 flops, so it lags pllLock by 2 cycles.
- IDLE:
  - Outputs: pllRst=1, pllStdby=1, pllEnClkop=0, lvdsResetN=0.
  - retryCount is cleared.
  - enableReq=1 -> RESET on the next edge; counter cleared.
- RESET:
  - Outputs: pllRst=1, pllStdby=0.
  - Counter counts to RST_CYCLES-1, then -> WAIT_LOCK with counters cleared.
  - pllRst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - Output: pllRst=0.
  - Timeout counter increments every cycle.
  - Stability counter increments while lockS=1 and clears to 0 when lockS=0.
  - When the stability counter reaches LOCK_STABLE_CYCLES-1 with lockS=1 -> RUN. This has priority over timeout in the same cycle.
  - Else, when the timeout counter reaches LOCK_TIMEOUT_CYCLES-1 -> failed attempt.
- RUN:
  - Output: pllEnClkop=1.
  - Gap counter runs; after ENABLE_GAP cycles, lvdsResetN=1 and retryCount clears to 0.
  - If lockS=0 in any RUN cycle, the next edge gives pllEnClkop=0 and lvdsResetN=0, and the attempt counts as failed.
- Failed attempt:
  - retryCount increments (saturating).
  - If the new count >= MAX_RETRIES -> FAULT, else -> RESET.
- FAULT:
  - Outputs: pllRst=1, pllStdby=1, pllEnClkop=0, lvdsResetN=0, fault=1.
  - Held until enableReq=0 -> IDLE; fault clears on that edge.
- enableReq=0 in any state -> IDLE on the next edge. This has priority over every other transition, including a lock-loss in the same cycle; retryCount is not incremented.
- enableReq re-asserted in the same cycle as IDLE entry is honoured on the following cycle (IDLE lasts a minimum of 1 cycle).
- Glitch rules:
  - A lockS glitch during WAIT_LOCK restarts only the stability counter, not the timeout counter.
  - Any lockS=0 cycle during RUN, including within the gap, is a lock loss.
- Async reset mid-operation returns all outputs to their reset values immediately.

Decomposition:
- Package lvds_pll_pkg holds:
  - state enum (IDLE, RESET, WAIT_LOCK, RUN, FAULT);
  - default timing constants;
  - retryCount width constant (2).
- One sub-module, sync_2ff, synchronises pllLock into lockS. It is reusable for other async inputs.

Test Plan (bench params: RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, ENABLE_GAP=2, MAX_RETRIES=2):
- Nominal start:
  - Stimulus: enableReq=1 at cycle 0; pllLock=1 from cycle 6.
  - Response: pllRst high cycles 1-4; stability counter starts at cycle 8 (2-cycle sync lag); pllEnClkop=1 at cycle 16; lvdsResetN=ready=1 at cycle 18; retryCount=0.
- Lock timeout:
  - Stimulus: pllLock held 0.
  - Response: after 4+32 cycles retryCount=1 and pllRst re-asserts; after the second timeout fault=1, retryCount=2 and outputs are in the FAULT pattern; enableReq=0 -> IDLE with fault=0 next edge.
- Lock loss in RUN:
  - Stimulus: pllLock drops for 1 cycle while ready=1.
  - Response: 2 cycles later, then 1 edge, pllEnClkop=0 and lvdsResetN=0; retryCount=1; pllRst high for 4 cycles; relock reaches ready=1 and retryCount returns to 0.
- Lock glitch in WAIT_LOCK:
  - Stimulus: pllLock=1 for 5 cycles, 0 for 1, then 1.
  - Response: no RUN until 8 consecutive lockS cycles; timeout count unaffected.
- Disable priority:
  - Stimulus: enableReq falls in the same cycle lockS falls in RUN.
  - Response: IDLE next edge; retryCount unchanged, then cleared in IDLE; fault stays 0.
- Async reset:
  - Stimulus: resetN pulsed low mid-WAIT_LOCK.
  - Response: outputs take their reset values immediately; state=IDLE; restart from IDLE when enableReq=1.

Source files
------------

// File: rtl/lvds_pll_pkg.sv
// lvds_pll_pkg: shared state encoding and default timing for the LVDS PLL sequencer
package lvds_pll_pkg;
  typedef enum logic [2:0] {IDLE, RESET, WAIT_LOCK, RUN, FAULT} state_t;
  localparam int DEF_CNT_W = 17;
  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 4800;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 48000;
  localparam int DEF_ENABLE_GAP = 8;
  localparam int DEF_MAX_RETRIES = 3;
  localparam int RETRY_W = 2;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/lvds_pll_sequencer.sv
// lvds_pll_sequencer: PLL power-up/lock sequencing with retry and fault latch for the LVDS serializer
module lvds_pll_sequencer
  import lvds_pll_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int ENABLE_GAP = DEF_ENABLE_GAP,
  parameter int MAX_RETRIES = DEF_MAX_RETRIES
) (
  input  logic               pllInClock,
  input  logic               resetN,
  input  logic               enableReq,
  input  logic               pllLock,
  output logic               pllRst,
  output logic               pllStdby,
  output logic               pllEnClkop,
  output logic               lvdsResetN,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retryCount
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  state_t state, nstate;
  logic lock_s, locked, fail, lvds_d;
  logic [CNT_W-1:0] cnt, cnt_d, stab, stab_d;
  logic [RETRY_W-1:0] retry_inc, retry_d;
  sync_2ff u_sync (.clk(pllInClock), .rst_n(resetN), .d(pllLock), .q(lock_s));
  assign locked = lock_s && stab == STABLE_LAST;
  assign ready = lvdsResetN;
  // stable lock wins over timeout; disable wins over everything, including a failed attempt
  always_comb begin
    nstate = state;
    fail = 1'b0;
    case (state)
      IDLE: nstate = RESET;
      RESET: nstate = (cnt == RST_LAST) ? WAIT_LOCK : RESET;
      WAIT_LOCK: begin
        nstate = locked ? RUN : WAIT_LOCK;
        fail = !locked && cnt == TIMEOUT_LAST;
      end
      RUN: fail = !lock_s;
      default: ;
    endcase
    retry_inc = &retryCount ? retryCount : retryCount + RETRY_W'(1);
    if (fail) nstate = (int'(retry_inc) >= MAX_RETRIES) ? FAULT : RESET;
    if (!enableReq) nstate = IDLE;
    lvds_d = nstate == RUN && state == RUN && int'(cnt) + 1 >= ENABLE_GAP;
    retry_d = (state == IDLE) ? '0 : !enableReq ? retryCount : fail ? retry_inc : lvds_d ? '0 : retryCount;
    cnt_d = (nstate != state || state == IDLE || state == FAULT) ? '0 :
            (state == RUN && int'(cnt) == ENABLE_GAP) ? cnt : cnt + CNT_W'(1);
    stab_d = (nstate == WAIT_LOCK && state == WAIT_LOCK && lock_s) ? stab + CNT_W'(1) : '0;
  end
  always_ff @(posedge pllInClock or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      cnt <= '0;
      stab <= '0;
      pllRst <= 1'b1;
      pllStdby <= 1'b1;
      pllEnClkop <= 1'b0;
      lvdsResetN <= 1'b0;
      fault <= 1'b0;
      retryCount <= '0;
    end else begin
      state <= nstate;
      cnt <= cnt_d;
      stab <= stab_d;
      pllRst <= nstate == IDLE || nstate == RESET || nstate == FAULT;
      pllStdby <= nstate == IDLE || nstate == FAULT;
      pllEnClkop <= nstate == RUN;
      lvdsResetN <= lvds_d;
      fault <= nstate == FAULT;
      retryCount <= retry_d;
    end
endmodule
